shadow_write_scheduler: RTL and testbench
=========================================

// Module: shadow_write_scheduler
// PURPOSE
//  Sequences the single port of the 128K slow RAM (banks E0/E1) between direct CPU accesses and
//  shadow write-through copies of CPU writes to banks 00/01 video regions. Shadow writes go into
//  a FIFO and drain in free slow-port cycles. cpu_wait stalls the core on FIFO full or ordering hazard.
// PARAMETERS
//  FIFO_DEPTH  8  shadow write queue entries; power of two, 2..32
//  DRAIN_DIV   2  minimum clk_sys cycles between successive FIFO drain writes (>=1)
// PORTS
//  clk_sys      in   1   system clock; the only clock
//  reset_n      in   1   synchronous, active-low reset
//  fast_clk     in   1   one-cycle CPU bus strobe; request fields sampled only when high
//  cpu_req      in   1   valid CPU memory access this strobe
//  cpu_we       in   1   1 = write
//  cpu_bank     in   8   CPU bank
//  cpu_addr     in   16  CPU address
//  cpu_dout     in   8   CPU write data
//  shadow       in   8   shadow register; bit=0 enables shadowing for that region
//  io           in   1   access decoded as I/O; never shadowed, never direct
//  cpu_wait     out  1   stall request to core; request fields held stable while high
//  slow_ce      out  1   slow RAM port enable
//  slow_we      out  1   slow RAM write enable
//  slow_addr    out  17  {bank[0], addr}
//  slow_din     out  8   slow RAM write data
//  fifo_level   out  6   current FIFO occupancy, 0..FIFO_DEPTH
//  shadow_cnt   out  16  shadow writes enqueued (SHADOW_STATS_EN only, else 0)
//  stall_cnt    out  16  clk_sys cycles with cpu_wait=1 (SHADOW_STATS_EN only, else 0)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, drain timer 0, state IDLE. Reset mid-stall drops queued entries.
//  Direct hit: bank E0/E1 and ~io. Shadow hit: cpu_we, bank 00/01, ~io and any of:
//   0400-07FF & ~shadow[0]; 0800-0BFF & ~shadow[5]; 2000-3FFF & ~shadow[1]; 4000-5FFF & ~shadow[2];
//   bank 01 only 2000-9FFF & ~shadow[3]. Bank 01 text/hires terms also need ~shadow[4].
//  Shadow entry = {bank[0], addr[15:0], data[7:0]}, 25 bits.
//  States: IDLE, DIRECT, WAIT_FULL, WAIT_ORDER.
//   IDLE, strobe, shadow hit, FIFO not full -> enqueue same cycle; stay IDLE.
//   IDLE, strobe, shadow hit, FIFO full -> WAIT_FULL; cpu_wait=1 next cycle; enqueue on first cycle
//    with a free slot (drain same cycle counts), then IDLE, cpu_wait=0 next cycle.
//   IDLE, strobe, direct hit, FIFO empty -> DIRECT: one cycle slow_ce=1, slow_we=cpu_we, addr/data
//    from CPU; back to IDLE. No cpu_wait.
//   IDLE, strobe, direct hit, FIFO not empty -> WAIT_ORDER: cpu_wait=1, drain until empty, then
//    DIRECT, then IDLE. Keeps E0/E1 read/write order after earlier shadow copies.
//  Drain: in IDLE/WAIT_FULL/WAIT_ORDER, FIFO not empty and drain timer expired -> pop head, drive
//   slow_ce=1, slow_we=1 one cycle, reload timer to DRAIN_DIV-1. DIRECT cycle has priority; no drain then.
//  Simultaneous enqueue and drain in one cycle: legal; level unchanged; full FIFO accepts in that cycle.
//  slow_* registered; 1 cycle latency from strobe/pop to port. Idle: slow_ce=0, slow_we=0, addr/data hold.
//  Pointers log2(FIFO_DEPTH) bits wrap modulo depth; level counter separate, never exceeds FIFO_DEPTH.
//  Strobes while cpu_wait=1 are the same held access; not re-decoded.
//  Non-hit strobes (fast RAM, ROM, io) pass with no effect.
// CONFIGURATION
//  SHADOW_STATS_EN defined: shadow_cnt +1 per enqueue, stall_cnt +1 per cycle cpu_wait=1; both
//   saturate at FFFF, clear on reset. Undefined: no counter logic, both outputs constant 0.
// TESTING
//  1 shadow=00, write 00:0400=41 -> level 1; next drain: slow_we=1, slow_addr=00400, slow_din=41.
//  2 shadow bit1=1, write 00:2000=AA -> no enqueue, level stays 0, no slow_ce.
//  3 DRAIN_DIV=8, 9 shadow writes back-to-back while full -> cpu_wait high until first pop,
//    all 9 drain in order, no drop.
//  4 level=3, CPU read E1:0401 -> cpu_wait until 3 drains done, then one slow_ce with slow_we=0,
//    slow_addr=10401.
//  5 bank 01 write 0400 with shadow[4]=1 -> no enqueue; same with shadow[3]=0, addr 6000 -> enqueue 16000.
//  6 reset_n=0 during WAIT_FULL -> next cycle cpu_wait=0, level=0, counters 0 (SHADOW_STATS_EN).

Source files
------------

// File: rtl/shadow_write_scheduler_if.sv
// CPU request/stall side, slow RAM port and status outputs of shadow_write_scheduler.
interface shadow_write_scheduler_if;
    logic        fast_clk;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_bank;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  shadow;
    logic        io;
    logic        cpu_wait;
    logic        slow_ce;
    logic        slow_we;
    logic [16:0] slow_addr;
    logic [7:0]  slow_din;
    logic [5:0]  fifo_level;
    logic [15:0] shadow_cnt;
    logic [15:0] stall_cnt;

    modport master (
        output fast_clk, cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_dout, shadow, io,
        input  cpu_wait, slow_ce, slow_we, slow_addr, slow_din, fifo_level, shadow_cnt, stall_cnt
    );

    modport slave (
        input  fast_clk, cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_dout, shadow, io,
        output cpu_wait, slow_ce, slow_we, slow_addr, slow_din, fifo_level, shadow_cnt, stall_cnt
    );
endinterface

// File: rtl/shadow_write_scheduler.sv
// Shares the slow RAM port between direct E0/E1 accesses and queued shadow copies of bank 00/01
// video writes. Define SHADOW_STATS_EN to build the enqueue and stall counters.
module shadow_write_scheduler #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DRAIN_DIV  = 2
) (
    input logic                     clk_sys,
    input logic                     reset_n,
    shadow_write_scheduler_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned TmrW = $clog2(DRAIN_DIV + 1);
    localparam logic [5:0] LevelMax = 6'(FIFO_DEPTH);
    localparam logic [TmrW-1:0] TmrReload = TmrW'(DRAIN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StDirect, StWaitFull, StWaitOrder} state_e;

    state_e          state_q, state_d;
    logic [24:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [5:0]      level_q, level_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            slow_ce_q, slow_ce_d, slow_we_q, slow_we_d;
    logic [16:0]     slow_addr_q, slow_addr_d;
    logic [7:0]      slow_din_q, slow_din_d;
    logic [24:0]     head;
    logic            strobe, lo_bank, bank1, legacy, shr, shadow_hit, direct_hit;
    logic            fifo_empty, room, pop, push, issue, cpu_wait;
    logic            unused_shadow;

    assign unused_shadow = ^bus.shadow[7:6];
    assign strobe  = bus.fast_clk & bus.cpu_req;
    assign lo_bank = (bus.cpu_bank[7:1] == 7'h00);
    assign bank1   = bus.cpu_bank[0];

    assign legacy = ((bus.cpu_addr[15:10] == 6'h01) & ~bus.shadow[0]) |
                    ((bus.cpu_addr[15:10] == 6'h02) & ~bus.shadow[5]) |
                    ((bus.cpu_addr[15:13] == 3'h1)  & ~bus.shadow[1]) |
                    ((bus.cpu_addr[15:13] == 3'h2)  & ~bus.shadow[2]);
    assign shr    = (bus.cpu_addr >= 16'h2000) & (bus.cpu_addr <= 16'h9fff) & ~bus.shadow[3];

    // Bank 01 legacy regions are additionally gated by shadow[4]; the SHR range is not.
    assign shadow_hit = bus.cpu_we & lo_bank & ~bus.io &
                        ((legacy & (~bank1 | ~bus.shadow[4])) | (bank1 & shr));
    assign direct_hit = (bus.cpu_bank[7:1] == 7'h70) & ~bus.io;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (level_q == 6'd0);
    assign pop        = (state_q != StDirect) & ~fifo_empty & (tmr_q == '0);
    assign room       = (level_q != LevelMax) | pop;
    assign cpu_wait   = (state_q == StWaitFull) | (state_q == StWaitOrder);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle, StDirect: begin
                state_d = StIdle;
                if (strobe && shadow_hit) begin
                    if (room) push = 1'b1;
                    else      state_d = StWaitFull;
                end else if (strobe && direct_hit) begin
                    if (fifo_empty) begin
                        issue   = 1'b1;
                        state_d = StDirect;
                    end else begin
                        state_d = StWaitOrder;
                    end
                end
            end
            StWaitFull: begin
                if (room) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitOrder: begin
                if (fifo_empty) begin
                    issue   = 1'b1;
                    state_d = StDirect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        slow_ce_d   = 1'b0;
        slow_we_d   = 1'b0;
        slow_addr_d = slow_addr_q;
        slow_din_d  = slow_din_q;
        if (issue) begin
            slow_ce_d   = 1'b1;
            slow_we_d   = bus.cpu_we;
            slow_addr_d = {bank1, bus.cpu_addr};
            slow_din_d  = bus.cpu_dout;
        end else if (pop) begin
            slow_ce_d   = 1'b1;
            slow_we_d   = 1'b1;
            slow_addr_d = head[24:8];
            slow_din_d  = head[7:0];
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + 6'd1;
            2'b01:   level_d = level_q - 6'd1;
            default: level_d = level_q;
        endcase

        if (pop)                tmr_d = TmrReload;
        else if (tmr_q != '0)   tmr_d = tmr_q - TmrW'(1);
        else                    tmr_d = tmr_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= 6'd0;
            tmr_q       <= '0;
            slow_ce_q   <= 1'b0;
            slow_we_q   <= 1'b0;
            slow_addr_q <= 17'd0;
            slow_din_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            tmr_q       <= tmr_d;
            slow_ce_q   <= slow_ce_d;
            slow_we_q   <= slow_we_d;
            slow_addr_q <= slow_addr_d;
            slow_din_q  <= slow_din_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= {bank1, bus.cpu_addr, bus.cpu_dout};
    end

    assign bus.cpu_wait   = cpu_wait;
    assign bus.slow_ce    = slow_ce_q;
    assign bus.slow_we    = slow_we_q;
    assign bus.slow_addr  = slow_addr_q;
    assign bus.slow_din   = slow_din_q;
    assign bus.fifo_level = level_q;

`ifdef SHADOW_STATS_EN
    logic [15:0] shadow_cnt_q, shadow_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        shadow_cnt_d = shadow_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (push && shadow_cnt_q != 16'hffff)    shadow_cnt_d = shadow_cnt_q + 16'd1;
        if (cpu_wait && stall_cnt_q != 16'hffff) stall_cnt_d  = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            shadow_cnt_q <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            shadow_cnt_q <= shadow_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.shadow_cnt = shadow_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;
`else
    assign bus.shadow_cnt = 16'd0;
    assign bus.stall_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_shadow_write_scheduler.sv
// Bench for shadow_write_scheduler: queue-based cycle model checked every cycle, plus directed
// scenarios with hand-computed port traffic.
module tb_shadow_write_scheduler;
    localparam int unsigned Depth = 8;
    localparam int unsigned Div   = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    shadow_write_scheduler_if bus ();

    shadow_write_scheduler #(
        .FIFO_DEPTH (Depth),
        .DRAIN_DIV  (Div)
    ) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the region table.
    function automatic bit m_shadow(input bit we, input bit io, input logic [7:0] bank,
                                    input logic [15:0] a, input logic [7:0] sh);
        int addr;
        addr = int'(a);
        if (!we || io || bank > 8'h01) return 1'b0;
        if (bank == 8'h01 && addr >= 'h2000 && addr <= 'h9fff && !sh[3]) return 1'b1;
        if (bank == 8'h01 && sh[4]) return 1'b0;
        return (addr >= 'h0400 && addr <= 'h07ff && !sh[0]) ||
               (addr >= 'h0800 && addr <= 'h0bff && !sh[5]) ||
               (addr >= 'h2000 && addr <= 'h3fff && !sh[1]) ||
               (addr >= 'h4000 && addr <= 'h5fff && !sh[2]);
    endfunction

    // Model: pending = 0 none, 1 shadow write blocked on full, 2 direct access waiting on order.
    logic [24:0] m_q[$];
    int          m_wait = 0;
    int          m_pend = 0;
    bit          m_after_direct = 1'b0;
    logic        m_ce = 1'b0, m_we = 1'b0;
    logic [16:0] m_addr = 17'd0;
    logic [7:0]  m_din = 8'd0;
    int          m_scnt = 0, m_stall = 0;

    always @(posedge clk) begin
        bit          strobe, can_pop, push, issue, sh_hit, dir_hit;
        logic [24:0] e;
        if (!reset_n) begin
            m_q.delete();
            m_wait = 0; m_pend = 0; m_after_direct = 1'b0;
            m_ce = 1'b0; m_we = 1'b0; m_addr = 17'd0; m_din = 8'd0;
            m_scnt = 0; m_stall = 0;
        end else begin
            if (m_pend != 0 && m_stall < 'hffff) m_stall++;
            strobe  = bus.fast_clk && bus.cpu_req;
            sh_hit  = m_shadow(bus.cpu_we, bus.io, bus.cpu_bank, bus.cpu_addr, bus.shadow);
            dir_hit = (bus.cpu_bank == 8'he0 || bus.cpu_bank == 8'he1) && !bus.io;
            can_pop = !m_after_direct && m_q.size() > 0 && m_wait == 0;
            push = 1'b0;
            issue = 1'b0;
            if (m_pend == 0) begin
                if (strobe && sh_hit) begin
                    if (m_q.size() < Depth || can_pop) push = 1'b1;
                    else m_pend = 1;
                end else if (strobe && dir_hit) begin
                    if (m_q.size() == 0) issue = 1'b1;
                    else m_pend = 2;
                end
            end else if (m_pend == 1) begin
                if (m_q.size() < Depth || can_pop) begin push = 1'b1; m_pend = 0; end
            end else begin
                if (m_q.size() == 0) begin issue = 1'b1; m_pend = 0; end
            end
            m_ce = 1'b0;
            m_we = 1'b0;
            if (issue) begin
                m_ce = 1'b1; m_we = bus.cpu_we;
                m_addr = {bus.cpu_bank[0], bus.cpu_addr}; m_din = bus.cpu_dout;
            end
            if (can_pop) begin
                e = m_q.pop_front();
                m_ce = 1'b1; m_we = 1'b1; m_addr = e[24:8]; m_din = e[7:0];
                m_wait = Div - 1;
            end else if (m_wait > 0) begin
                m_wait--;
            end
            if (push) begin
                m_q.push_back({bus.cpu_bank[0], bus.cpu_addr, bus.cpu_dout});
                if (m_scnt < 'hffff) m_scnt++;
            end
            m_after_direct = issue;
        end
    end

    always @(negedge clk) begin
        check("cpu_wait", bus.cpu_wait, m_pend != 0);
        check("slow_ce", bus.slow_ce, m_ce);
        check("slow_we", bus.slow_we, m_we);
        check("slow_addr", bus.slow_addr, m_addr);
        check("slow_din", bus.slow_din, m_din);
        check("fifo_level", bus.fifo_level, m_q.size());
`ifdef SHADOW_STATS_EN
        check("shadow_cnt", bus.shadow_cnt, m_scnt);
        check("stall_cnt", bus.stall_cnt, m_stall);
`else
        check("shadow_cnt", bus.shadow_cnt, 0);
        check("stall_cnt", bus.stall_cnt, 0);
`endif
    end

    // Port traffic log: {we, addr, din}.
    logic [25:0] log_q[$];
    bit          stall_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.slow_ce) log_q.push_back({bus.slow_we, bus.slow_addr, bus.slow_din});
        if (bus.cpu_wait) stall_seen = 1'b1;
    end

    task automatic access(input bit we, input logic [7:0] bank, input logic [15:0] addr,
                          input logic [7:0] d, input bit no_wait);
        int n;
        n = 0;
        bus.cpu_we   = we;
        bus.cpu_bank = bank;
        bus.cpu_addr = addr;
        bus.cpu_dout = d;
        bus.fast_clk = 1'b1;
        bus.cpu_req  = 1'b1;
        @(negedge clk);
        bus.fast_clk = 1'b0;
        bus.cpu_req  = 1'b0;
        if (!no_wait) begin
            while (bus.cpu_wait && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("stall_release", bus.cpu_wait, 0);
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((bus.fifo_level != 6'd0 || bus.cpu_wait) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("settle", {bus.cpu_wait, bus.fifo_level}, 0);
        repeat (Div + 2) @(negedge clk);
    endtask

    initial begin
        int n;
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish by 2ms");
        $fatal(1);
    end

    initial begin
        int n;
        bus.fast_clk = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_bank = 8'h00;
        bus.cpu_addr = 16'h0000; bus.cpu_dout = 8'h00; bus.shadow = 8'hff; bus.io = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", {bus.cpu_wait, bus.slow_ce, bus.slow_we, bus.fifo_level}, 0);
        check("rst_addr", bus.slow_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Text page 1 write shadowed, then drained
        bus.shadow = 8'h00;
        log_q.delete();
        access(1'b1, 8'h00, 16'h0400, 8'h41, 1'b0);
        check("t1_level", bus.fifo_level, 1);
        settle();
        check("t1_count", log_q.size(), 1);
        check("t1_drain", log_q[0], {1'b1, 17'h00400, 8'h41});

        // Hires 1 disabled
        bus.shadow = 8'h02;
        log_q.delete();
        access(1'b1, 8'h00, 16'h2000, 8'haa, 1'b0);
        check("t2_level", bus.fifo_level, 0);
        repeat (12) @(negedge clk);
        check("t2_no_ce", log_q.size(), 0);

        // I/O-decoded accesses have no effect
        bus.shadow = 8'h00;
        bus.io = 1'b1;
        log_q.delete();
        access(1'b1, 8'h00, 16'h0400, 8'h33, 1'b0);
        check("io_level", bus.fifo_level, 0);
        access(1'b0, 8'he0, 16'h0010, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("io_no_ce", log_q.size(), 0);
        bus.io = 1'b0;

        // Bank 01: shadow[4] blocks text, SHR still shadowed
        bus.shadow = 8'h10;
        log_q.delete();
        access(1'b1, 8'h01, 16'h0400, 8'h55, 1'b0);
        check("t5_text_level", bus.fifo_level, 0);
        access(1'b1, 8'h01, 16'h6000, 8'h5a, 1'b0);
        check("t5_shr_level", bus.fifo_level, 1);
        settle();
        check("t5_count", log_q.size(), 1);
        check("t5_drain", log_q[0], {1'b1, 17'h16000, 8'h5a});

        // Direct read must wait for queued copies
        bus.shadow = 8'h00;
        log_q.delete();
        stall_seen = 1'b0;
        for (int i = 0; i < 4; i++) access(1'b1, 8'h00, 16'(16'h0400 + i), 8'(i + 1), 1'b0);
        check("t4_level", bus.fifo_level, 3);
        access(1'b0, 8'he1, 16'h0401, 8'h77, 1'b0);
        check("t4_stalled", stall_seen, 1);
        settle();
        check("t4_count", log_q.size(), 5);
        check("t4_last_copy", log_q[3], {1'b1, 17'h00403, 8'h04});
        check("t4_direct", log_q[4], {1'b0, 17'h10401, 8'h77});

        // Back-to-back writes overflow the queue; nothing dropped, order kept
        log_q.delete();
        stall_seen = 1'b0;
        for (int i = 0; i < 18; i++) access(1'b1, 8'h00, 16'(16'h2000 + i), 8'(8'h10 + i), 1'b0);
        settle();
        check("t3_stalled", stall_seen, 1);
        check("t3_count", log_q.size(), 18);
        for (int i = 0; i < 18; i++)
            check("t3_order", log_q[i], {1'b1, 1'b0, 16'(16'h2000 + i), 8'(8'h10 + i)});

        // Reset while blocked on full
        n = 0;
        while (!bus.cpu_wait && n < 40) begin
            access(1'b1, 8'h00, 16'(16'h4000 + n), 8'(n), 1'b1);
            n++;
        end
        check("t6_stalled", bus.cpu_wait, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_wait", bus.cpu_wait, 0);
        check("t6_level", bus.fifo_level, 0);
        check("t6_counters", {bus.shadow_cnt, bus.stall_cnt}, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
